// File: rtl/nand_page_reader.sv
// nand_page_reader
// Read stage of the A->B NAND copy path. For each accepted start the block
// issues a read command (00h/01h) and three address cycles to flash A. It then
// waits tWB and for ready/busy, and strobes F_REN to fetch BURST_LEN bytes.
// The bytes go into a small FIFO that feeds a valid/ready byte port. When the
// FIFO has no room, further REN pulses wait, so no byte is dropped under
// backpressure.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start, addr       one-cycle request (ignored while busy); addr is latched on accept
//   busy, done, err   busy covers the whole operation; done and err are one-cycle pulses
//   m_data, m_valid,  FIFO head byte and valid; m_ready is the downstream accept
//   m_ready
//   F_IO              flash data bus; driven only while issuing command/address
//   F_CLE, F_ALE      command / address latch enables
//   F_REN, F_WEN      read / write enables, active low
//   F_RB              flash ready(1) / busy(0)
//
// Optional feature: define NAND_RD_TIMEOUT_EN to abort with an err pulse if
// F_RB stays low for TOUT_CYC cycles. Without it, the wait has no limit and
// err stays 0.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; flash pins at rest
// CMD     | two cycles: CLE with WEN low, then WEN high (00h/01h)
// ADDR    | six cycles: three WEN low/high pairs carrying column, row[7:0], row[8]
// TWB     | tWB hold-off after the last address; F_RB not yet trusted
// WAIT_RB | waiting for F_RB=1 (optionally time-limited)
// READ    | REN low/high pulses, one byte captured per pulse
// DRAIN   | all bytes fetched; waiting for the FIFO to empty
module nand_page_reader #(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TWB_CYC    = 2,
  parameter int TOUT_CYC   = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [17:0] addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  inout  wire  [7:0]  F_IO,
  output logic        F_CLE,
  output logic        F_ALE,
  output logic        F_REN,
  output logic        F_WEN,
  input  logic        F_RB
);

  // The tWB wait and the RB timeout share one down-counter, sized for the longer of the two.
  localparam int TMR_MAX = (TOUT_CYC > TWB_CYC) ? TOUT_CYC : TWB_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_TWB, S_WAIT_RB, S_READ, S_DRAIN
  } state_t;

  state_t             state;
  logic [2:0]         step;
  logic [2:0]         step_nxt;
  logic [TMR_W-1:0]   timer;
  logic [7:0]         bytes_left;
  logic [16:0]        addr_q;      // {row[8:0], column[7:0]}; the half-page bit only selects the command
  logic [7:0]         io_out;
  logic               io_oe;

  logic [7:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               push;
  logic               pop;
  logic               last_pop;
  logic               rb_timeout;

  function automatic logic [7:0] addr_byte(input logic [1:0] idx, input logic [16:0] a);
    case (idx)
      2'd0:    return a[7:0];
      2'd1:    return a[15:8];
      default: return {7'b0, a[16]};
    endcase
  endfunction

  assign F_IO     = io_oe ? io_out : 8'bz;
  assign step_nxt = step + 3'd1;

  // Data is captured on the edge where REN returns high, which is the edge
  // that ends the REN-low cycle.
  assign push     = (state == S_READ) && !F_REN;
  assign pop      = m_valid && m_ready;
  assign last_pop = (state == S_DRAIN) && (fifo_cnt == CNT_W'(1)) && m_ready;
  assign done     = last_pop;
  assign m_valid  = (fifo_cnt != '0);
  assign m_data   = mem[rd_ptr];

`ifdef NAND_RD_TIMEOUT_EN
  assign rb_timeout = (state == S_WAIT_RB) && !F_RB && (timer == '0);
`else
  assign rb_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      step       <= '0;
      timer      <= '0;
      bytes_left <= '0;
      addr_q     <= '0;
      io_out     <= '0;
      io_oe      <= 1'b0;
      F_CLE      <= 1'b0;
      F_ALE      <= 1'b0;
      F_REN      <= 1'b1;
      F_WEN      <= 1'b1;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= rb_timeout;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q <= {addr[17:9], addr[7:0]};
            io_out <= addr[8] ? 8'h01 : 8'h00;
            io_oe  <= 1'b1;
            F_CLE  <= 1'b1;
            F_WEN  <= 1'b0;
            busy   <= 1'b1;
            step   <= '0;
            state  <= S_CMD;
          end
        end
        S_CMD: begin
          if (step == 3'd0) begin
            F_WEN <= 1'b1;
            step  <= 3'd1;
          end else begin
            F_CLE  <= 1'b0;
            F_ALE  <= 1'b1;
            F_WEN  <= 1'b0;
            io_out <= addr_byte(2'd0, addr_q);
            step   <= '0;
            state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          // Even steps hold WEN low and odd steps hold it high; a new byte
          // goes on the bus with each low phase.
          if (step == 3'd5) begin
            F_ALE <= 1'b0;
            io_oe <= 1'b0;
            timer <= TMR_W'(TWB_CYC - 1);
            state <= S_TWB;
          end else begin
            step <= step_nxt;
            if (!step[0]) begin
              F_WEN <= 1'b1;
            end else begin
              F_WEN  <= 1'b0;
              io_out <= addr_byte(step_nxt[2:1], addr_q);
            end
          end
        end
        S_TWB: begin
          if (timer == '0) begin
            timer <= TMR_W'(TOUT_CYC - 1);
            state <= S_WAIT_RB;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_WAIT_RB: begin
          if (F_RB) begin
            bytes_left <= 8'(BURST_LEN - 1);
            state      <= S_READ;
          end else if (rb_timeout) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            timer <= timer - TMR_W'(1);
          end
        end
        S_READ: begin
          if (!F_REN) begin
            F_REN <= 1'b1;
            if (bytes_left == 8'd0) state <= S_DRAIN;
            else                    bytes_left <= bytes_left - 8'd1;
          end else if (fifo_cnt < CNT_W'(FIFO_DEPTH)) begin
            // A pulse starts only when the byte it fetches has a FIFO slot.
            F_REN <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= F_IO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (rb_timeout) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
